// File: rtl/fifo_uart_tx_if.sv
// Handshake bundle between the UART transmitter, its upstream FIFO and the
// serial line. The master side is the transmitter; the slave side is the
// FIFO/line environment.
interface fifo_uart_tx_if #(
    parameter int DATA_WID = 8
);
    logic                tx_en;
    logic                fifo_empty;
    logic                fifo_data_vld;
    logic [DATA_WID-1:0] fifo_data;
    logic                fifo_rd_en;
    logic                tx;
    logic                busy;
    logic                frame_done;
    logic                err_underrun;

    modport master (
        input  tx_en,
        input  fifo_empty,
        input  fifo_data_vld,
        input  fifo_data,
        output fifo_rd_en,
        output tx,
        output busy,
        output frame_done,
        output err_underrun
    );

    modport slave (
        output tx_en,
        output fifo_empty,
        output fifo_data_vld,
        output fifo_data,
        input  fifo_rd_en,
        input  tx,
        input  busy,
        input  frame_done,
        input  err_underrun
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmitter fed from a synchronous FIFO. Reads one character per
// frame, waits a bounded time for the read data, then sends start bit,
// DATA_WID data bits LSB first and one stop bit.
//
// state | meaning
// IDLE  | line high, waiting for tx_en with a non-empty FIFO
// FETCH | one-cycle FIFO read request
// WAIT  | waiting up to 4 cycles for read data; timeout flags underrun
// START | start bit (line low)
// DATA  | data bits, LSB first
// STOP  | stop bit (line high); frame_done on its last cycle
module fifo_uart_tx #(
    parameter int DATA_WID     = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input logic             clk,
    input logic             rst,
    fifo_uart_tx_if.master  bus
);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_WID > 1) ? $clog2(DATA_WID) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DATA_WID-1:0] shift_q, shift_d;
    logic [1:0]          wait_q, wait_d;
    logic                err_q, err_d;
    logic                baud_last;
    logic                bit_last;

    assign baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    assign bit_last  = (bit_q == BIT_W'(DATA_WID - 1));

    // State, counters, shift register and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; the baud counter clears whenever a bit period ends.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        wait_d  = wait_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                wait_d = '0;
                if (bus.tx_en && !bus.fifo_empty) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                wait_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.fifo_data_vld) begin
                    shift_d = bus.fifo_data;
                    baud_d  = '0;
                    state_d = START;
                end else if (wait_q == 2'd3) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_last) begin
                        bit_d   = '0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode directly from state so reset forces them without a clock.
    always_comb begin
        bus.fifo_rd_en   = (state_q == FETCH);
        bus.busy         = (state_q != IDLE);
        bus.frame_done   = (state_q == STOP) && baud_last;
        bus.err_underrun = err_q;
        case (state_q)
            START:   bus.tx = 1'b0;
            DATA:    bus.tx = shift_q[0];
            default: bus.tx = 1'b1;
        endcase
    end
endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clk and rst.
REQ-002 Parameter DATA_WID SHALL default to 8 and set the character width in bits.
REQ-003 Parameter CLKS_PER_BIT SHALL default to 16 and set clk cycles per serial bit; legal values are 2 and above.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 tx_en  input  1  permits starting new frames.
REQ-007 fifo_empty  input  1  empty flag of the upstream sync FIFO.
REQ-008 fifo_data_vld  input  1  upstream FIFO read-data valid strobe.
REQ-009 fifo_data  input  DATA_WID  upstream FIFO read data.
REQ-010 fifo_rd_en  output  1  single-cycle read request to the FIFO.
REQ-011 tx  output  1  serial line, idle high.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 frame_done  output  1  one-cycle pulse at the end of each stop bit.
REQ-014 err_underrun  output  1  sticky flag: a FIFO read returned no data.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, FETCH, WAIT, START, DATA and STOP.
REQ-016 IDLE SHALL go to FETCH when tx_en=1 and fifo_empty=0; otherwise it SHALL stay in IDLE.
REQ-017 fifo_rd_en SHALL be 1 only during the single cycle spent in FETCH; FETCH SHALL always go to WAIT.
REQ-018 In WAIT, fifo_data_vld=1 SHALL load fifo_data into the shift register and move the FSM to START.
REQ-019 fifo_data_vld SHALL be ignored in every state other than WAIT.
REQ-020 If WAIT lasts 4 cycles with no fifo_data_vld, the FSM SHALL return to IDLE and set err_underrun; no frame is sent.
REQ-021 err_underrun SHALL clear only on reset.
REQ-022 tx SHALL be 0 throughout START, shift-register bit 0 throughout DATA, and 1 in all other states.
REQ-023 START, each DATA bit and STOP SHALL each last exactly CLKS_PER_BIT cycles, timed by a baud counter that runs 0..CLKS_PER_BIT-1 and clears on every bit transition.
REQ-024 DATA SHALL send DATA_WID bits LSB first, shifting right once per bit; a bit counter SHALL move the FSM from DATA to STOP after bit DATA_WID-1.
REQ-025 frame_done SHALL pulse for the last cycle of STOP, after which the FSM SHALL enter IDLE.
REQ-026 tx_en SHALL be sampled only in IDLE; deasserting it mid-frame SHALL let the current frame finish.
REQ-027 Minimum gap between back-to-back frames SHALL be exactly 3 cycles of tx=1 (IDLE, FETCH, WAIT), given fifo_data_vld arrives on the first WAIT cycle.
REQ-028 The block SHALL issue exactly one fifo_rd_en per frame and SHALL never assert fifo_rd_en while fifo_empty=1.

Reset
REQ-029 While rst=1, independent of clk: FSM=IDLE, tx=1, fifo_rd_en=0, busy=0, frame_done=0, err_underrun=0, and all counters and the shift register are 0.
REQ-030 Reset during a frame SHALL abort it at once; the aborted character is lost, and no rd_en is reissued for it.
REQ-031 After rst falls, the FSM SHALL leave IDLE on the first rising edge that meets REQ-016.

Verification (DATA_WID=8, CLKS_PER_BIT=4)
REQ-032 Assert rst asynchronously -> tx=1, busy=0, fifo_rd_en=0, frame_done=0, err_underrun=0 before the next clk edge.
REQ-033 FIFO holds 0xA5, tx_en=1 -> one rd_en pulse; tx = 0, then 1,0,1,0,0,1,0,1, then 1, each held 4 cycles; one frame_done pulse.
REQ-034 FIFO holds 0xA1, 0xB2, 0xC3, with fifo_data_vld one cycle after rd_en -> three frames decode correctly, with exactly 3 idle-high cycles between each stop bit and the next start bit.
REQ-035 tx_en falls during DATA bit 2 of 0xD4 with 0xE5 still queued -> 0xD4 completes, no further rd_en, 0xE5 stays in the FIFO.
REQ-036 rd_en issued but fifo_data_vld held 0 -> return to IDLE after 4 WAIT cycles, err_underrun=1 and stays 1, tx stays 1 throughout.
REQ-037 rst pulsed during DATA bit 3 -> tx=1 immediately; after release with the FIFO non-empty, the next frame starts from FETCH.
